// File: rtl/ym3438_timer_bank.sv
// YM3438-style timer bank: N independent prescaled up-counters with
// reload on overflow, one-shot/auto-reload modes and sticky flags.
module ym3438_timer_bank #(
    parameter int NUM_TIMERS = 2,
    parameter int CNT_WIDTH  = 10
) (
    input  logic                            MCLK,
    input  logic                            IC,
    input  logic                            tick,
    input  logic [NUM_TIMERS-1:0]           load,
    input  logic [NUM_TIMERS*CNT_WIDTH-1:0] load_val,
    input  logic [NUM_TIMERS*3-1:0]         pre_shift,
    input  logic [NUM_TIMERS-1:0]           one_shot,
    input  logic [NUM_TIMERS-1:0]           irq_en,
    input  logic [NUM_TIMERS-1:0]           clr_flag,
    output logic [NUM_TIMERS*CNT_WIDTH-1:0] cnt,
    output logic [NUM_TIMERS-1:0]           flag,
    output logic [NUM_TIMERS-1:0]           ovf_pulse,
    output logic                            irq
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_HALT
    } state_t;

    for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_tmr
        state_t               st_q;
        logic                 ld_q;
        logic [6:0]           pre_q;
        logic [CNT_WIDTH-1:0] cnt_q;
        logic                 flag_q;
        logic                 ovf_q;

        logic [CNT_WIDTH-1:0] lv;
        logic [2:0]           ps;
        logic [7:0]           lim;
        logic                 rise;
        logic                 stop;
        logic                 adv;
        logic                 step;
        logic                 wrap;
        logic                 set;

        assign lv   = load_val[i*CNT_WIDTH +: CNT_WIDTH];
        assign ps   = pre_shift[i*3 +: 3];
        assign lim  = (8'd1 << ps) - 8'd1;
        assign rise = load[i] & ~ld_q;
        assign stop = ~load[i] & (st_q != S_IDLE);
        // A start in the same cycle as a tick suppresses the count
        assign adv  = load[i] & ~rise & (st_q == S_RUN) & tick;
        assign step = adv & ({1'b0, pre_q} >= lim);
        assign wrap = step & (&cnt_q);
        assign set  = wrap & irq_en[i];

        always_ff @(posedge MCLK or negedge IC) begin
            if (!IC) begin
                st_q   <= S_IDLE;
                ld_q   <= 1'b0;
                pre_q  <= '0;
                cnt_q  <= '0;
                flag_q <= 1'b0;
                ovf_q  <= 1'b0;
            end else begin
                ld_q  <= load[i];
                ovf_q <= wrap;
                if (set) begin
                    flag_q <= 1'b1;
                end else if (clr_flag[i]) begin
                    flag_q <= 1'b0;
                end
                if (rise) begin
                    cnt_q <= lv;
                    pre_q <= '0;
                    st_q  <= S_RUN;
                end else if (stop) begin
                    pre_q <= '0;
                    st_q  <= S_IDLE;
                end else if (adv) begin
                    if (step) begin
                        pre_q <= '0;
                        if (wrap) begin
                            cnt_q <= lv;
                            if (one_shot[i]) begin
                                st_q <= S_HALT;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end else begin
                        pre_q <= pre_q + 7'd1;
                    end
                end
            end
        end

        assign cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
        assign flag[i]      = flag_q;
        assign ovf_pulse[i] = ovf_q;
    end

    assign irq = |flag;

endmodule
